// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache/memory access port between NUM_REQ requesters.
// One transaction in flight; each ends on mem_ack (done) or watchdog expiry (err).
module cache_port_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [NUM_REQ-1:0]          err,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_d, done_d, err_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  logic                found;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W:0]      pos;
  logic [IDX_W:0]      adv;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
      if (!found && req[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = pos[IDX_W-1:0];
      end
    end
  end

  // Pointer value used after a transaction finishes: winner + 1, wrapped.
  always_comb begin
    adv = {1'b0, win_q} + (IDX_W+1)'(1);
    if (adv >= (IDX_W+1)'(NUM_REQ)) adv = '0;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = '0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ISSUE;
          win_d       = pick;
          gnt_d       = NUM_REQ'(1) << pick;
          mem_req_d   = 1'b1;
          mem_we_d    = req_we[pick];
          mem_addr_d  = addr_arr[pick];
          mem_wdata_d = wdata_arr[pick];
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Ack takes priority over the watchdog on the final cycle.
        if (mem_ack) begin
          done_d    = NUM_REQ'(1) << win_q;
          rdata_d   = mem_we ? '0 : mem_rdata;
          mem_req_d = 1'b0;
          gnt_d     = '0;
          rr_ptr_d  = adv[IDX_W-1:0];
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d     = NUM_REQ'(1) << win_q;
          mem_req_d = 1'b0;
          gnt_d     = '0;
          rr_ptr_d  = adv[IDX_W-1:0];
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      done      <= done_d;
      err       <= err_d;
      rdata     <= rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule
